// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_pkg
// Brief    : Shared types and default widths for the MAC operand sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    localparam int c_len_w    = 8;
    localparam int c_mult_lat = 1;
    localparam int c_op_w     = 8;
    localparam int c_acc_w    = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_en_delay.sv
`default_nettype none
// ============================================================================
// Module   : mac_en_delay
// Brief    : DEPTH-deep valid shift register that lines the MAC enable up
//            with the multiplier pipeline; empty reports no beat in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mac_en_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic vld_in,
    output logic vld_out,
    output logic empty
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) r_sr <= '0;
                else         r_sr <= vld_in;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) r_sr <= '0;
                else         r_sr <= {r_sr[DEPTH-2:0], vld_in};
            end
        end
    endgenerate

    assign vld_out = r_sr[DEPTH-1];
    assign empty   = ~|r_sr;

endmodule
`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer
// Brief    : Feeds B/C operand pairs to a pipelined MAC for one dot product
//            per job and returns the captured accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LEN_W    = c_len_w,
    parameter int MULT_LAT = c_mult_lat
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    input  logic [LEN_W-1:0]   vec_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [c_op_w-1:0]  in_b,
    input  logic [c_op_w-1:0]  in_c,
    output logic [c_op_w-1:0]  mac_b,
    output logic [c_op_w-1:0]  mac_c,
    output logic               mac_en,
    output logic               mac_rst,
    input  logic [c_acc_w-1:0] mac_acc,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [c_acc_w-1:0] res_data,
    output logic               busy
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             r_vld;
    logic             w_beat;
    logic             w_last;
    logic             w_empty;
    logic             w_drained;
    logic             w_clr;

    assign w_beat    = in_valid & in_ready;
    assign w_cnt_inc = r_cnt + LEN_W'(1);
    assign w_last    = (w_cnt_inc == r_len);
    // Final add has landed once nothing is queued and mac_en is already low.
    assign w_drained = ~r_vld & w_empty;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = (r_len == '0) ? DRAIN : FEED;
            FEED:    if (w_beat && w_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = RESULT;
            RESULT:  if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        w_clr     = 1'b0;
        case (r_state)
            IDLE:    busy      = 1'b0;
            CLEAR:   w_clr     = 1'b1;
            FEED:    in_ready  = 1'b1;
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // The MAC must clear together with this block, so reset feeds straight through.
    assign mac_rst = ~nreset | w_clr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            mac_b    <= '0;
            mac_c    <= '0;
            res_data <= '0;
        end else begin
            r_vld <= w_beat;
            if (r_state == IDLE && start) begin
                r_len <= vec_len;
                r_cnt <= '0;
            end
            if (w_beat) begin
                mac_b <= in_b;
                mac_c <= in_c;
                r_cnt <= w_cnt_inc;
            end
            if (r_state == DRAIN && w_drained) res_data <= mac_acc;
        end
    end

    mac_en_delay #(
        .DEPTH (MULT_LAT)
    ) u_en_delay (
        .clk     (clk),
        .nreset  (nreset),
        .vld_in  (r_vld),
        .vld_out (mac_en),
        .empty   (w_empty)
    );

endmodule
`default_nettype wire
